// File: rtl/ace_snoop_responder_if.sv
// Bus bundle for the ACE snoop responder: AC/CR/CD snoop channels plus the
// tag-lookup, data-read and state-update ports toward the local cache arrays.
interface ace_snoop_responder_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BEAT_W     = 3
);
  // Every *_valid/*_ready pair transfers on a clock edge where both are high;
  // a source holds valid and its payload stable until that edge. rd_rvalid and
  // lu_rvalid are single-cycle result strobes with no ready.
  logic                  ac_valid;
  logic                  ac_ready;
  logic [ADDR_WIDTH-1:0] ac_addr;
  logic [3:0]            ac_snoop;
  logic [2:0]            ac_prot;
  logic                  cr_valid;
  logic                  cr_ready;
  logic [4:0]            cr_resp;
  logic                  cd_valid;
  logic                  cd_ready;
  logic [DATA_WIDTH-1:0] cd_data;
  logic                  cd_last;
  logic                  lu_valid;
  logic                  lu_ready;
  logic [ADDR_WIDTH-1:0] lu_addr;
  logic                  lu_rvalid;
  logic                  lu_hit;
  logic                  lu_dirty;
  logic                  lu_unique;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [BEAT_W-1:0]     rd_beat;
  logic                  rd_rvalid;
  logic [DATA_WIDTH-1:0] rd_rdata;
  logic                  upd_valid;
  logic                  upd_ready;
  logic                  upd_inval;

  modport slave (
    input  ac_valid, ac_addr, ac_snoop, ac_prot, cr_ready, cd_ready,
           lu_ready, lu_rvalid, lu_hit, lu_dirty, lu_unique,
           rd_ready, rd_rvalid, rd_rdata, upd_ready,
    output ac_ready, cr_valid, cr_resp, cd_valid, cd_data, cd_last,
           lu_valid, lu_addr, rd_valid, rd_beat, upd_valid, upd_inval
  );

  modport master (
    output ac_valid, ac_addr, ac_snoop, ac_prot, cr_ready, cd_ready,
           lu_ready, lu_rvalid, lu_hit, lu_dirty, lu_unique,
           rd_ready, rd_rvalid, rd_rdata, upd_ready,
    input  ac_ready, cr_valid, cr_resp, cd_valid, cd_data, cd_last,
           lu_valid, lu_addr, rd_valid, rd_beat, upd_valid, upd_inval
  );
endinterface

// File: rtl/ace_snoop_responder.sv
// Cached-master snoop endpoint: one snoop at a time, lookup -> CRRESP ->
// optional full-line CD stream through a 2-entry credit-limited FIFO -> state update.
module ace_snoop_responder #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_BYTES = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  ace_snoop_responder_if.slave bus,
  output logic [2:0]          dbg_state_o
);
  localparam int BEATS  = LINE_BYTES / (DATA_WIDTH / 8);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_LU, SEND_CR, SEND_CD, UPDATE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            snoop_q, snoop_d;
  logic [4:0]            resp_q, resp_d;
  logic                  upd_q, upd_d, inval_q, inval_d;
  logic                  ac_ready_q, ac_ready_d;
  logic [BEAT_W:0]       rd_cnt_q, rd_cnt_d;
  logic [BEAT_W-1:0]     out_cnt_q, out_cnt_d;
  logic [1:0]            outst_q, outst_d, fifo_cnt_q, fifo_cnt_d;
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic [DATA_WIDTH-1:0] fifo_d [2];

  logic supported, rd_en, rd_credit, rd_fire, push, pop, last_pop;
  logic unused_prot;

  assign unused_prot = ^bus.ac_prot;

  always_comb begin
    supported = 1'b0;
    case (bus.ac_snoop)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0111, 4'b1000, 4'b1001, 4'b1101: supported = 1'b1;
      default:                            supported = 1'b0;
    endcase
  end

  // Buffered plus in-flight beats never exceed the two FIFO slots.
  assign rd_en     = (state_q == SEND_CR || state_q == SEND_CD) && resp_q[0] && !rd_cnt_q[BEAT_W];
  assign rd_credit = ({1'b0, fifo_cnt_q} + {1'b0, outst_q}) < 3'd2;
  assign rd_fire   = rd_en && rd_credit && bus.rd_ready;
  assign push      = bus.rd_rvalid && (outst_q != 2'd0);
  assign pop       = (state_q == SEND_CD) && (fifo_cnt_q != 2'd0) && bus.cd_ready;
  assign last_pop  = pop && (out_cnt_q == LAST_BEAT);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    snoop_d    = snoop_q;
    resp_d     = resp_q;
    upd_d      = upd_q;
    inval_d    = inval_q;
    rd_cnt_d   = rd_cnt_q + (BEAT_W+1)'(rd_fire);
    out_cnt_d  = out_cnt_q + BEAT_W'(pop);
    outst_d    = outst_q + 2'(rd_fire) - 2'(push);
    fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop);
    wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d   = pop ? ~rd_ptr_q : rd_ptr_q;
    fifo_d     = fifo_q;
    if (push) fifo_d[wr_ptr_q] = bus.rd_rdata;

    case (state_q)
      IDLE: begin
        if (bus.ac_valid && ac_ready_q) begin
          addr_d  = bus.ac_addr & LINE_MASK;
          snoop_d = bus.ac_snoop;
          upd_d   = 1'b0;
          inval_d = 1'b0;
          if (supported) begin
            resp_d  = 5'b00000;
            state_d = LOOKUP;
          end else begin
            resp_d  = 5'b00010;
            state_d = SEND_CR;
          end
        end
      end
      LOOKUP: if (bus.lu_ready) state_d = WAIT_LU;
      WAIT_LU: begin
        if (bus.lu_rvalid) begin
          resp_d  = 5'b00000;
          state_d = SEND_CR;
          if (bus.lu_hit) begin
            resp_d[4] = bus.lu_unique;
            case (snoop_q)
              4'b0000: begin resp_d[3] = 1'b1; resp_d[0] = 1'b1; end
              4'b0001, 4'b0010, 4'b0011: begin
                resp_d[3] = 1'b1; resp_d[2] = bus.lu_dirty; resp_d[0] = 1'b1;
                upd_d = 1'b1;
              end
              4'b0111: begin
                resp_d[2] = bus.lu_dirty; resp_d[0] = 1'b1;
                upd_d = 1'b1; inval_d = 1'b1;
              end
              4'b1001: begin
                resp_d[2] = bus.lu_dirty; resp_d[0] = bus.lu_dirty;
                upd_d = 1'b1; inval_d = 1'b1;
              end
              4'b1000: begin
                resp_d[3] = 1'b1; resp_d[2] = bus.lu_dirty; resp_d[0] = bus.lu_dirty;
                upd_d = 1'b1;
              end
              4'b1101: begin upd_d = 1'b1; inval_d = 1'b1; end
              default: ;
            endcase
          end
        end
      end
      SEND_CR: begin
        if (bus.cr_ready) begin
          if (resp_q[0])  state_d = SEND_CD;
          else if (upd_q) state_d = UPDATE;
          else            state_d = IDLE;
        end
      end
      SEND_CD: begin
        if (last_pop) begin
          rd_cnt_d = '0;
          state_d  = upd_q ? UPDATE : IDLE;
        end
      end
      UPDATE: if (bus.upd_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ac_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      snoop_q    <= '0;
      resp_q     <= '0;
      upd_q      <= 1'b0;
      inval_q    <= 1'b0;
      ac_ready_q <= 1'b0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      outst_q    <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      snoop_q    <= snoop_d;
      resp_q     <= resp_d;
      upd_q      <= upd_d;
      inval_q    <= inval_d;
      ac_ready_q <= ac_ready_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      outst_q    <= outst_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_q     <= fifo_d;
    end
  end

  assign bus.ac_ready  = ac_ready_q;
  assign bus.lu_valid  = (state_q == LOOKUP);
  assign bus.lu_addr   = addr_q;
  assign bus.cr_valid  = (state_q == SEND_CR);
  assign bus.cr_resp   = resp_q;
  assign bus.cd_valid  = (state_q == SEND_CD) && (fifo_cnt_q != 2'd0);
  assign bus.cd_data   = fifo_q[rd_ptr_q];
  assign bus.cd_last   = bus.cd_valid && (out_cnt_q == LAST_BEAT);
  assign bus.rd_valid  = rd_en && rd_credit;
  assign bus.rd_beat   = rd_cnt_q[BEAT_W-1:0];
  assign bus.upd_valid = (state_q == UPDATE);
  assign bus.upd_inval = inval_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder: cache lookup/read models, CD scoreboard
// with an expected-beat queue, and per-snoop response/update checks.
module tb_ace_snoop_responder;
  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  ace_snoop_responder_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .BEAT_W(3)) bus ();

  ace_snoop_responder #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .LINE_BYTES(64)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int          n_checks, n_errors;
  logic [63:0] exp_q[$];
  logic        lu_hit_cfg, lu_dirty_cfg, lu_unique_cfg, cd_toggle;
  logic [7:0]  line_tag;
  int          rd_issued, cd_beats, upd_count, lu_cycles, cr_count, max_inflight;
  logic        upd_inval_seen, held_v, lu_p1, rd_v1;
  logic [63:0] held_data, lu_addr_seen;
  logic [2:0]  rd_b1;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // cache array models: lookup latency 2, read latency 2
  assign bus.lu_hit    = lu_hit_cfg;
  assign bus.lu_dirty  = lu_dirty_cfg;
  assign bus.lu_unique = lu_unique_cfg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_p1         <= 1'b0;
      bus.lu_rvalid <= 1'b0;
      rd_v1         <= 1'b0;
      rd_b1         <= 3'd0;
      bus.rd_rvalid <= 1'b0;
      bus.rd_rdata  <= 64'd0;
    end else begin
      lu_p1         <= bus.lu_valid && bus.lu_ready;
      bus.lu_rvalid <= lu_p1;
      rd_v1         <= bus.rd_valid && bus.rd_ready;
      rd_b1         <= bus.rd_beat;
      bus.rd_rvalid <= rd_v1;
      bus.rd_rdata  <= {line_tag, 52'h0, 1'b0, rd_b1};
    end
  end

  always @(posedge clk) begin
    #1;
    bus.cd_ready = cd_toggle ? ~bus.cd_ready : 1'b1;
  end

  // monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.lu_valid) begin
        lu_cycles++;
        lu_addr_seen = bus.lu_addr;
      end
      if (bus.cr_valid && bus.cr_ready) cr_count++;
      if (rd_issued - cd_beats > max_inflight) max_inflight = rd_issued - cd_beats;
      if (bus.rd_valid && bus.rd_ready) begin
        check("rd_beat_order", 64'(bus.rd_beat), 64'(rd_issued));
        rd_issued++;
      end
      if (held_v && bus.cd_valid) check("cd_hold_stable", bus.cd_data, held_data);
      held_v    = bus.cd_valid && !bus.cd_ready;
      held_data = bus.cd_data;
      if (bus.cd_valid && bus.cd_ready) begin
        if (exp_q.size() > 0) check("cd_data", bus.cd_data, exp_q.pop_front());
        check("cd_last", 64'(bus.cd_last), 64'(cd_beats == 7));
        cd_beats++;
      end
      if (bus.upd_valid && bus.upd_ready) begin
        upd_count++;
        upd_inval_seen = bus.upd_inval;
      end
    end
  end

  task automatic clear_counts();
    rd_issued = 0; cd_beats = 0; upd_count = 0; lu_cycles = 0; cr_count = 0;
    max_inflight = 0; held_v = 1'b0; lu_addr_seen = '0;
  endtask

  task automatic start_snoop(input string name, input logic [63:0] addr, input logic [3:0] snp,
                             input logic hit, input logic dirty, input logic uniq, input int exp_beats);
    bit ok;
    lu_hit_cfg = hit; lu_dirty_cfg = dirty; lu_unique_cfg = uniq;
    line_tag = line_tag + 8'd1;
    clear_counts();
    for (int i = 0; i < exp_beats; i++) exp_q.push_back({line_tag, 52'h0, 1'b0, 3'(i)});
    @(posedge clk); #1;
    bus.ac_valid = 1'b1; bus.ac_addr = addr; bus.ac_snoop = snp;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.ac_ready;
    end
    @(posedge clk); #1;
    bus.ac_valid = 1'b0;
    check({name, ":ac_accept"}, 64'(ok), 64'd1);
  endtask

  task automatic do_snoop(input string name, input logic [63:0] addr, input logic [3:0] snp,
                          input logic hit, input logic dirty, input logic uniq,
                          input logic [4:0] exp_resp, input int exp_beats, input int exp_upd,
                          input logic exp_inval, input bit exp_lu, input bit chk_ready);
    bit ok;
    start_snoop(name, addr, snp, hit, dirty, uniq, exp_beats);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.cr_valid;
    end
    check({name, ":cr_seen"}, 64'(ok), 64'd1);
    check({name, ":cr_resp"}, 64'(bus.cr_resp), 64'(exp_resp));
    if (chk_ready) begin
      @(negedge clk);
      check({name, ":ready_after_cr"}, 64'(bus.ac_ready), 64'd1);
    end
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = bus.ac_ready && (dbg_state == 3'd0);
    end
    check({name, ":back_to_idle"}, 64'(ok), 64'd1);
    check({name, ":cr_count"}, 64'(cr_count), 64'd1);
    check({name, ":cd_beats"}, 64'(cd_beats), 64'(exp_beats));
    check({name, ":rd_issued"}, 64'(rd_issued), 64'(exp_beats));
    check({name, ":exp_q_empty"}, 64'(exp_q.size()), 64'd0);
    check({name, ":inflight_max2"}, 64'(max_inflight <= 2), 64'd1);
    check({name, ":upd_count"}, 64'(upd_count), 64'(exp_upd));
    if (exp_upd != 0) check({name, ":upd_inval"}, 64'(upd_inval_seen), 64'(exp_inval));
    if (exp_lu) check({name, ":lu_addr"}, lu_addr_seen, {addr[63:6], 6'b0});
    else        check({name, ":no_lookup"}, 64'(lu_cycles), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    bit ok;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    bus.ac_valid = 1'b0; bus.ac_addr = '0; bus.ac_snoop = '0; bus.ac_prot = '0;
    bus.cr_ready = 1'b1; bus.lu_ready = 1'b1; bus.rd_ready = 1'b1; bus.upd_ready = 1'b1;
    cd_toggle = 1'b0; lu_hit_cfg = 1'b0; lu_dirty_cfg = 1'b0; lu_unique_cfg = 1'b0;
    line_tag = 8'd0; upd_inval_seen = 1'b0;
    clear_counts();
    repeat (3) @(negedge clk);
    check("reset:ctrl_outputs", 64'({bus.ac_ready, bus.cr_valid, bus.cr_resp, bus.cd_valid, bus.cd_last,
          bus.lu_valid, bus.rd_valid, bus.rd_beat, bus.upd_valid, bus.upd_inval, dbg_state}), 64'd0);
    check("reset:cd_data", bus.cd_data, 64'd0);
    rst_n = 1'b1;

    do_snoop("miss",        64'h1000, 4'b0001, 1'b0, 1'b0, 1'b0, 5'b00000, 0, 0, 1'b0, 1'b1, 1'b1);
    do_snoop("rs_dirty_uq", 64'h2047, 4'b0001, 1'b1, 1'b1, 1'b1, 5'b11101, 8, 1, 1'b0, 1'b1, 1'b0);
    cd_toggle = 1'b1;
    do_snoop("ru_toggle",   64'h3010, 4'b0111, 1'b1, 1'b0, 1'b0, 5'b00001, 8, 1, 1'b1, 1'b1, 1'b0);
    cd_toggle = 1'b0;
    do_snoop("make_inval",  64'h4080, 4'b1101, 1'b1, 1'b1, 1'b1, 5'b10000, 0, 1, 1'b1, 1'b1, 1'b0);
    do_snoop("unsupported", 64'h5000, 4'b1111, 1'b1, 1'b1, 1'b1, 5'b00010, 0, 0, 1'b0, 1'b0, 1'b0);
    do_snoop("clean_shrd",  64'h5100, 4'b1000, 1'b1, 1'b1, 1'b0, 5'b01101, 8, 1, 1'b0, 1'b1, 1'b0);
    do_snoop("clean_inv",   64'h5200, 4'b1001, 1'b1, 1'b0, 1'b1, 5'b10000, 0, 1, 1'b1, 1'b1, 1'b0);

    // reset in the middle of a CD stream
    start_snoop("rst_mid", 64'h6000, 4'b0001, 1'b1, 1'b1, 1'b0, 8);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = (cd_beats >= 4);
    end
    check("rst_mid:reached_beat3", 64'(ok), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid:ctrl_outputs", 64'({bus.ac_ready, bus.cr_valid, bus.cr_resp, bus.cd_valid, bus.cd_last,
          bus.lu_valid, bus.rd_valid, bus.rd_beat, bus.upd_valid, bus.upd_inval, dbg_state}), 64'd0);
    check("rst_mid:cd_data", bus.cd_data, 64'd0);
    exp_q.delete();
    clear_counts();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_mid:no_cr_after", 64'(cr_count), 64'd0);
    check("rst_mid:no_cd_after", 64'(cd_beats + rd_issued), 64'd0);
    check("rst_mid:no_upd_after", 64'(upd_count), 64'd0);
    do_snoop("ro_after_rst", 64'h7000, 4'b0000, 1'b1, 1'b0, 1'b0, 5'b01001, 8, 0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ace_snoop_responder.md
Name: ace_snoop_responder

Overview:
- Cached-master-side endpoint of the ACE snoop channels (AC in, CR/CD out); answers snoops issued by the CCU snoop controllers.
- Per snoop: looks up the local cache, returns a CRRESP, streams the full line on CD when DataTransfer=1, then commits the cache state change.
- One snoop outstanding at a time. Sits between the snoop crossbar master port and the cache tag/data arrays.

Parameters:
- ADDR_WIDTH, 64, AC address width
- DATA_WIDTH, 64, CD data width (bits)
- LINE_BYTES, 64, cache line size; BEATS = LINE_BYTES/(DATA_WIDTH/8) (default 8), must be >= 2 and a power of 2

Ports:
- clk_i in 1 clock
- rst_ni in 1 async active-low reset
- ac_valid_i / ac_ready_o in/out 1 snoop address handshake
- ac_addr_i in ADDR_WIDTH snoop address
- ac_snoop_i in 4 ACSNOOP
- ac_prot_i in 3 ACPROT (ignored)
- cr_valid_o / cr_ready_i out/in 1 snoop response handshake
- cr_resp_o out 5 {WasUnique, IsShared, PassDirty, Error, DataTransfer}, bit 4..0
- cd_valid_o / cd_ready_i out/in 1 snoop data handshake
- cd_data_o out DATA_WIDTH data beat
- cd_last_o out 1 last beat
- lu_valid_o / lu_ready_i out/in 1 tag lookup request
- lu_addr_o out ADDR_WIDTH line-aligned lookup address
- lu_rvalid_i in 1 lookup result valid (any latency >= 1 cycle)
- lu_hit_i / lu_dirty_i / lu_unique_i in 1 each lookup result
- rd_valid_o / rd_ready_i out/in 1 data-array read request
- rd_beat_o out $clog2(BEATS) beat index
- rd_rvalid_i in 1 read data valid; no backpressure
- rd_rdata_i in DATA_WIDTH read data
- upd_valid_o / upd_ready_i out/in 1 state update request
- upd_inval_o out 1 1 = invalidate line, 0 = make SharedClean (dirty=0, unique=0)

Behaviour:
- Reset: rst_ni asynchronous, active-low; clock clk_i. All valids 0, ac_ready_o 0, cr_resp_o 0, cd_last_o 0, counters 0, FIFO empty, FSM IDLE. Reset mid-operation aborts the snoop; no CR/CD/update issued afterwards.
- FSM states: IDLE, LOOKUP, WAIT_LU, SEND_CR, SEND_CD, UPDATE.
- IDLE: ac_ready_o=1. On AC handshake, register addr (low log2(LINE_BYTES) bits cleared) and snoop -> LOOKUP.
- LOOKUP: lu_valid_o=1 until lu_ready_i -> WAIT_LU. Unsupported ACSNOOP skips LOOKUP and goes straight to SEND_CR with Error=1, all other bits 0.
- WAIT_LU: on lu_rvalid_i, compute and register the response -> SEND_CR.
  - Miss: all bits 0, no update.
  - Hit: WasUnique = unique.
  - ReadOnce (0000): DT=1, IsShared=1, PassDirty=0, no update.
  - ReadShared / ReadClean / ReadNotSharedDirty (0001/0010/0011): DT=1, IsShared=1, PassDirty=dirty, update SharedClean.
  - ReadUnique (0111): DT=1, PassDirty=dirty, IsShared=0, update invalidate.
  - CleanInvalid (1001): DT=dirty, PassDirty=dirty, invalidate.
  - CleanShared (1000): DT=dirty, PassDirty=dirty, IsShared=1, update SharedClean.
  - MakeInvalid (1101): DT=0, invalidate.
- SEND_CR: cr_valid_o=1 with stable cr_resp_o until cr_ready_i. On handshake: DT=1 -> SEND_CD; update pending -> UPDATE; otherwise -> IDLE.
- SEND_CD read side: issue rd_valid_o for beats 0..BEATS-1 in order. Issue only while fifo_count + outstanding < 2 (2-entry FIFO, credit-limited; overflow impossible). Read responses are pushed into the FIFO.
- SEND_CD output side: cd_valid_o = FIFO non-empty; cd_data_o = FIFO head. cd_last_o=1 when the output beat counter == BEATS-1. Hold data stable under backpressure.
  - Reads may be issued during SEND_CR; lookup of the data array must precede any update.
  - Simultaneous push and pop in one cycle is allowed; the count is unchanged.
  - After the last CD handshake: update pending -> UPDATE, else -> IDLE.
- UPDATE: upd_valid_o=1 until upd_ready_i -> IDLE.
- Beat counters wrap to 0 when the snoop completes.
- Minimum latency: AC handshake to cr_valid_o = 2 cycles + lookup latency. No new AC is accepted before the return to IDLE.

Test Plan:
- Miss: ReadShared to 0x1000, lu_hit=0 -> CR=5'b00000, no CD, no upd_valid_o, ac_ready_o high again 1 cycle after CR handshake.
- Dirty unique hit: ReadShared, hit=1, dirty=1, unique=1 -> CR=5'b11101, 8 CD beats with cd_last on beat 7, then upd_valid_o with upd_inval_o=0.
- ReadUnique on clean shared hit with cd_ready toggling every other cycle -> CR=5'b00001, beats in order with no drop or duplicate, never more than 2 reads outstanding plus buffered, then invalidate.
- MakeInvalid on dirty hit -> CR=5'b10000 with unique=1, no CD, upd_inval_o=1.
- ACSNOOP=4'b1111 -> CR=5'b00010, lu_valid_o never asserted.
- rst_ni asserted after CD beat 3 -> all outputs 0 asynchronously. A following ReadOnce completes with CR=5'b01001 and 8 fresh beats starting at rd_beat_o=0.
